// File: rtl/sram_like_responder_pkg.sv
// sram_like_responder_pkg: shared FSM states, access-size codes and wait-counter width
// for the sram-like responder and its SRAM model.
package sram_like_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/sram_sp_1r1w.sv
// sram_sp_1r1w: behavioural synchronous single-port SRAM, one-cycle read latency,
// per-byte write enables, read-first on a write cycle.
module sram_sp_1r1w #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++)
                if (wen[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sram_like_responder.sv
// sram_like_responder: sram-like slave backed by a one-cycle synchronous SRAM,
// with a fixed number of wait states between acceptance and data_ok.
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int WAIT   = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    input  logic [3:0]        data_wstrb,
    output logic [31:0]       data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rd_q, rd_d;
    logic [31:0]        hold_q, hold_d;
    logic               unused_ok;

    assign unused_ok = ^{data_size, data_addr[31:ADDR_W+2], data_addr[1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            rd_q   <= 1'b0;
            hold_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            rd_q   <= rd_d;
            hold_q <= hold_d;
        end
    end

    // rd_q marks the cycle after a read accept, the only cycle ram_rdata is captured
    always_comb begin
        state_d = data_addr_ok ? (WAIT == 0 ? RESP : BUSY)
                : state_q == BUSY ? (cnt_q == 1 ? RESP : BUSY)
                : IDLE;
        cnt_d   = data_addr_ok ? WAIT_C : state_q == BUSY ? cnt_q - 1'b1 : cnt_q;
        rd_d    = data_addr_ok && !data_wr;
        hold_d  = rd_q ? ram_rdata : hold_q;
    end

    // bypass the holding register in the capture cycle so WAIT=0 reads return data with data_ok
    always_comb begin
        data_addr_ok = resetn && data_req && (state_q == IDLE || state_q == RESP);
        data_data_ok = state_q == RESP;
        data_rdata   = rd_q ? ram_rdata : hold_q;
        ram_en       = data_addr_ok;
        ram_wen      = (data_addr_ok && data_wr) ? data_wstrb : 4'h0;
        ram_addr     = data_addr[ADDR_W+1:2];
        ram_wdata    = data_wdata;
    end

endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder: three responders (WAIT 0/3/5) each on its own SRAM, checked
// by a word-array reference model feeding per-instance scoreboards.
module tb_sram_like_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic        rstn  [3];
    logic        req   [3];
    logic        wr    [3];
    logic [1:0]  size  [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  strb  [3];
    logic [31:0] rdata [3];
    logic        aok   [3];
    logic        dok   [3];
    logic        ren   [3];
    logic [3:0]  rwen  [3];
    logic [11:0] raddr [3];
    logic [31:0] rwd   [3];
    logic [31:0] rrd   [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int W = (g == 0) ? 0 : (g == 1) ? 3 : 5;

        typedef struct {
            int          due;
            logic [31:0] data;
        } exp_t;

        exp_t        q[$];
        bit   [31:0] mem [int];
        int          free = 0;
        logic [31:0] prev = '0;
        logic        acc;
        int          idx;

        sram_like_responder #(.ADDR_W(12), .WAIT(W)) dut (
            .clk(clk), .resetn(rstn[g]), .data_req(req[g]), .data_wr(wr[g]),
            .data_size(size[g]), .data_addr(addr[g]), .data_wdata(wdata[g]),
            .data_wstrb(strb[g]), .data_rdata(rdata[g]), .data_addr_ok(aok[g]),
            .data_data_ok(dok[g]), .ram_en(ren[g]), .ram_wen(rwen[g]),
            .ram_addr(raddr[g]), .ram_wdata(rwd[g]), .ram_rdata(rrd[g])
        );

        sram_sp_1r1w #(.ADDR_W(12)) ram (
            .clk(clk), .en(ren[g]), .wen(rwen[g]), .addr(raddr[g]),
            .wdata(rwd[g]), .rdata(rrd[g])
        );

        // reference: one transaction per WAIT+1 cycles, responses due WAIT+1 after acceptance
        always @(negedge clk) begin
            if (!rstn[g]) begin
                chk("rst_addr_ok", 32'(aok[g]), 32'd0);
                chk("rst_ram_en", 32'(ren[g]), 32'd0);
                chk("rst_ram_wen", 32'(rwen[g]), 32'd0);
                q.delete();
                free = 0;
                prev = '0;
            end else begin
                acc = req[g] && cyc >= free;
                chk("addr_ok", 32'(aok[g]), 32'(acc));
                chk("ram_en", 32'(ren[g]), 32'(acc));
                if (acc) begin
                    idx = int'(addr[g][13:2]);
                    chk("ram_wen", 32'(rwen[g]), wr[g] ? 32'(strb[g]) : 32'd0);
                    chk("ram_addr", 32'(raddr[g]), 32'(addr[g][13:2]));
                    if (wr[g]) begin
                        chk("ram_wdata", rwd[g], wdata[g]);
                        for (int b = 0; b < 4; b++)
                            if (strb[g][b]) mem[idx][8*b +: 8] = wdata[g][8*b +: 8];
                    end else begin
                        prev = mem[idx];
                    end
                    q.push_back('{cyc + 1 + W, prev});
                    free = cyc + 1 + W;
                end
            end
        end

        always @(negedge clk) begin
            exp_t e;
            if (!rstn[g]) begin
                chk("rst_data_ok", 32'(dok[g]), 32'd0);
                chk("rst_rdata", rdata[g], 32'd0);
            end else if (dok[g]) begin
                if (q.size() == 0) chk("spurious_data_ok", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    chk("latency", 32'(cyc), 32'(e.due));
                    chk("rdata", rdata[g], e.data);
                end
            end else if (q.size() != 0 && cyc > q[0].due) begin
                chk("missing_data_ok", 32'd0, 32'd1);
                e = q.pop_front();
            end
        end
    end

    task automatic issue(input int d, input bit w, input logic [31:0] a,
                         input logic [31:0] dat, input logic [3:0] s);
        int n = 0;
        req[d]   = 1'b1;
        wr[d]    = w;
        addr[d]  = a;
        wdata[d] = dat;
        strb[d]  = s;
        size[d]  = 2'd2;
        @(negedge clk);
        while (!aok[d] && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (!aok[d]) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d, input int n);
        req[d] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_ops(input int d);
        for (int k = 0; k < 50; k++) begin
            issue(d, 1'($urandom_range(0, 1)),
                  ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 15)) << 2),
                  $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0) idle(d, $urandom_range(1, 3));
        end
        idle(d, 1);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rstn[d] = 1'b0; req[d] = 1'b1; wr[d] = 1'b0; size[d] = 2'd2;
            addr[d] = 32'h100; wdata[d] = '0; strb[d] = 4'hF;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0;
            rstn[d] = 1'b1;
        end
        @(posedge clk);
        #1;

        for (int d = 0; d < 3; d++) begin
            for (int w = 0; w < 16; w++) issue(d, 1'b1, 32'(w) << 2, $urandom, 4'hF);
            issue(d, 1'b1, 32'h100, 32'h0, 4'hF);
            idle(d, 1);
        end

        issue(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        issue(0, 1'b0, 32'h100, 32'h0, 4'h0);
        issue(0, 1'b1, 32'h100, 32'h000000AA, 4'b0001);
        issue(0, 1'b0, 32'h100, 32'h0, 4'h0);
        idle(0, 2);

        for (int w = 0; w < 16; w++) issue(0, 1'b0, 32'(w) << 2, 32'h0, 4'h0);
        idle(0, 2);

        issue(1, 1'b0, 32'h8, 32'h0, 4'h0);
        issue(1, 1'b0, 32'hC, 32'h0, 4'h0);
        idle(1, 6);

        issue(2, 1'b0, 32'h4, 32'h0, 4'h0);
        req[2] = 1'b0;
        @(posedge clk);
        #1;
        rstn[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn[2] = 1'b1;
        req[2] = 1'b1; wr[2] = 1'b0; addr[2] = 32'h8;
        @(negedge clk);
        chk("post_reset_accept", 32'(aok[2]), 32'd1);
        @(posedge clk);
        #1;
        idle(2, 10);

        fork
            rand_ops(0);
            rand_ops(1);
            rand_ops(2);
        join
        idle(0, 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/sram_like_responder.md
# sram_like_responder

Slave (responder) end of the sram-like data interface (`req`/`wr`/`size`/`addr`/`wdata`/`wstrb` in, `addr_ok`/`data_ok`/`rdata` out) that the CPU data port and dcache front-end drive as initiators. It backs the interface with a synchronous single-port SRAM (one-cycle read latency), optionally inserting a fixed number of wait states. It serves as an uncached scratchpad/data-RAM target and as a bench stand-in for the dcache.

## Interface
Parameters:
- `ADDR_W`, 12 — RAM word-index width; RAM holds 2^ADDR_W 32-bit words.
- `WAIT`, 0 — extra cycles between acceptance and `data_ok` (0..15).

Ports:
- `clk` in 1 — the single clock; all state updates on its rising edge.
- `resetn` in 1 — asynchronous, active-low reset.
- `data_req` in 1 — request valid.
- `data_wr` in 1 — 1 = write, 0 = read.
- `data_size` in 2 — 0 byte, 1 half, 2 word; informational only, `wstrb` governs writes.
- `data_addr` in 32 — byte address; bits `[ADDR_W+1:2]` index the RAM, all others ignored.
- `data_wdata` in 32 — write data.
- `data_wstrb` in 4 — byte enables for writes.
- `data_rdata` out 32 — read data, valid when `data_ok`=1 for a read.
- `data_addr_ok` out 1 — request accepted this cycle.
- `data_data_ok` out 1 — one-cycle completion pulse for reads and writes.
- `ram_en` out 1, `ram_wen` out 4, `ram_addr` out ADDR_W, `ram_wdata` out 32 — SRAM port.
- `ram_rdata` in 32 — SRAM read data, valid the cycle after `ram_en`.

## Operation
- FSM states: IDLE, BUSY, RESP.
- Acceptance: `data_addr_ok = data_req && (state==IDLE || state==RESP)`. This is combinational from `data_req`. An accept cycle T is any cycle with `data_req && data_addr_ok`.
- At T the SRAM is driven combinationally from the request:
  - `ram_en=1`;
  - `ram_wen = data_wr ? data_wstrb : 0`;
  - `ram_addr = data_addr[ADDR_W+1:2]`;
  - `ram_wdata = data_wdata`.
  - The request type (read/write) is registered.
- Transitions on accept: `WAIT==0` → RESP; otherwise → BUSY with `cnt=WAIT`.
- BUSY: `cnt` decrements each cycle; when `cnt==1` → RESP. `data_addr_ok=0` throughout BUSY.
- RESP:
  - `data_data_ok=1` for exactly this cycle.
  - If a new request is accepted in the same cycle → re-enter per the accept rule.
  - Otherwise → IDLE.
- Read data: `ram_rdata` is captured into a holding register in cycle T+1 only. `data_rdata` drives the holding register. For writes it is don't-care, but the bench expects the previous value to be held.
- In-order, single outstanding transaction. Write then read to the same word in consecutive accepts returns the new data.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, `cnt=0`, holding reg=0. Outputs during reset: `data_addr_ok=0`, `data_data_ok=0`, `data_rdata=0`, `ram_en=0`, `ram_wen=0`.
- Latency: `data_data_ok` at T+1+WAIT.
- Throughput: one transaction per WAIT+1 cycles. With `WAIT=0`, back-to-back requests complete every cycle.
- Simultaneous `data_data_ok` and accept in RESP is legal and required.
- `data_req` held high while `addr_ok=0` must not be accepted or reach the SRAM. The initiator may change the request fields freely until accepted.
- Reset mid-transaction (BUSY or RESP): the transaction is dropped with no `data_ok` after reset. A write already issued to the SRAM at T stays committed.

## Structure
- Shared package: FSM state enum (IDLE/BUSY/RESP), size encodings (`SIZE_BYTE`/`SIZE_HALF`/`SIZE_WORD`), and `WAIT` counter width constant (4).
- One natural sub-module: `sram_sp_1r1w`, the behavioural synchronous SRAM with per-byte write enables, used by the bench and FPGA top. The responder itself stays one module.

## Test plan
- **Reset:** hold `resetn=0` with `data_req=1`. Expect `addr_ok=0`, `data_ok=0`, `rdata=0`.
- **Write then read, WAIT=0:**
  - write `0xDEADBEEF` to `0x100` with `wstrb=4'hF`, then read `0x100` the next cycle;
  - expect `addr_ok` in both cycles;
  - expect `data_ok` at T+1 and T+2, with read `rdata=0xDEADBEEF`.
- **Byte strobe:** after the above, write `0x000000AA` with `wstrb=4'b0001`, then read. Expect `0xDEADBEAA`.
- **Wait states, WAIT=3:**
  - read accepted at T, `data_ok` at T+4;
  - `data_req` held high over T+1..T+3 sees `addr_ok=0` and no `ram_en`;
  - the next request is accepted at T+4.
- **Back-to-back stream, WAIT=0:** 16 consecutive reads. Expect 16 `data_ok` pulses on consecutive cycles, with data matching a preloaded pattern, in order.
- **Reset mid-operation, WAIT=5:**
  - assert `resetn=0` two cycles after accept;
  - expect no `data_ok` afterwards and state IDLE;
  - a following read accepts immediately.
